// File: rtl/ads42_cfg_pkg.sv
// Shared definitions for the ADS42 SPI configuration responder: sequencer
// states, register map constants and frame-word builders.
package ads42_cfg_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_INIT_FRAME,
    ST_INIT_SETTLE,
    ST_IDLE,
    ST_M_LOAD,
    ST_M_FRAME,
    ST_GAP,
    ST_D_LOAD,
    ST_D_FRAME,
    ST_SETTLE,
    ST_DONE
  } cfg_state_e;

  localparam int         FRAME_BITS    = 16;
  localparam logic [7:0] RST_ADDR_DEF  = 8'h08;
  localparam logic [7:0] RST_DATA      = 8'h01;
  localparam logic [7:0] MODE_ADDR_DEF = 8'h0F;
  localparam logic [7:0] DLY_ADDR_DEF  = 8'h42;
  localparam int         DLY_EN_BIT    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Test-pattern mode sits in the upper nibble of the register.
  function automatic logic [FRAME_BITS-1:0] mode_word(input logic [7:0] addr,
                                                      input logic [3:0] mode);
    return {addr, mode, 4'b0000};
  endfunction

  function automatic logic [FRAME_BITS-1:0] dly_word(input logic [7:0] addr,
                                                     input logic [2:0] dly);
    logic [7:0] data;
    data             = 8'h00;
    data[DLY_EN_BIT] = 1'b1;
    data[2:0]        = dly;
    return {addr, data};
  endfunction

endpackage

// File: rtl/ads42_spi_cfg_spi_word_tx.sv
// Serialises one 16-bit word onto the 3-wire SPI bus: SEN low for 33 half
// periods, data shifted MSB first and changed only on SCLK falling edges.
module spi_word_tx
  import ads42_cfg_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sen,
  output logic                  o_sclk,
  output logic                  o_sdata
);

  localparam int              DW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [4:0]      LAST_BIT = 5'(FRAME_BITS);

  logic                  busy_q,  busy_d;
  logic                  sclk_q,  sclk_d;
  logic                  sdata_q, sdata_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DW-1:0]         div_q,   div_d;
  logic [4:0]            bit_q,   bit_d;
  logic                  div_last;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    shift_d  = shift_q;
    div_d    = div_q;
    bit_d    = bit_q;
    o_done   = 1'b0;
    div_last = (div_q == DIV_LAST);

    if (!busy_q) begin
      if (i_load) begin
        busy_d  = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = i_data[FRAME_BITS-1];
        shift_d = {i_data[FRAME_BITS-2:0], 1'b0};
        div_d   = '0;
        bit_d   = '0;
      end
    end else begin
      div_d = div_last ? '0 : div_q + 1'b1;
      if (div_last) begin
        if (sclk_q) begin
          // Falling edge: present the next bit for the ADC's rising-edge sample.
          sclk_d  = 1'b0;
          bit_d   = bit_q + 1'b1;
          sdata_d = shift_q[FRAME_BITS-1];
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end else if (bit_q == LAST_BIT) begin
          busy_d  = 1'b0;
          sdata_d = 1'b0;
          bit_d   = '0;
          o_done  = 1'b1;
        end else begin
          sclk_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled at the same edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_sen   = ~busy_q;
  assign o_sclk  = sclk_q;
  assign o_sdata = sdata_q;

endmodule

// File: rtl/ads42_spi_cfg.sv
// ADS42 configuration sequencer: soft-reset after power-up, then serves
// calibration requests (mode + delay writes) over a four-phase handshake.
module ads42_spi_cfg
  import ads42_cfg_pkg::*;
#(
  parameter int         SCLK_DIV      = 4,
  parameter int         PWRUP_CYCLES  = 1024,
  parameter int         GAP_CYCLES    = 8,
  parameter int         SETTLE_CYCLES = 256,
  parameter logic [7:0] RST_ADDR      = RST_ADDR_DEF,
  parameter logic [7:0] MODE_ADDR     = MODE_ADDR_DEF,
  parameter logic [7:0] DLY_ADDR      = DLY_ADDR_DEF
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [3:0] i_ad_mode,
  input  logic [2:0] i_ad_dly,
  input  logic       i_ad_cal_start,
  output logic       o_ad_cal_over,
  output logic       o_ad_inital_over,
  output logic       o_spi_sen,
  output logic       o_spi_sclk,
  output logic       o_spi_sdata
);

  localparam int            WAIT_MAX    = max3(PWRUP_CYCLES, SETTLE_CYCLES, GAP_CYCLES);
  localparam int            WW          = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] PWRUP_LAST  = WW'(PWRUP_CYCLES - 1);
  localparam logic [WW-1:0] GAP_LAST    = WW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE_CYCLES - 1);

  cfg_state_e            state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [3:0]            mode_q, mode_d;
  logic [2:0]            dly_q, dly_d;
  logic                  cal_over_q, cal_over_d;
  logic                  inital_over_q, inital_over_d;
  logic                  tx_load, tx_busy, tx_done;
  logic [FRAME_BITS-1:0] tx_data;

  // The wait counter defaults to zero, so it clears on every state exit.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    mode_d        = mode_q;
    dly_d         = dly_q;
    cal_over_d    = cal_over_q;
    inital_over_d = inital_over_q;
    tx_load       = 1'b0;
    tx_data       = '0;

    unique case (state_q)
      ST_PWRUP: begin
        if (wait_q == PWRUP_LAST) state_d = ST_INIT_LOAD;
        else                      wait_d  = wait_q + 1'b1;
      end
      ST_INIT_LOAD: begin
        tx_data = {RST_ADDR, RST_DATA};
        if (!tx_busy) begin
          tx_load = 1'b1;
          state_d = ST_INIT_FRAME;
        end
      end
      ST_INIT_FRAME: if (tx_done) state_d = ST_INIT_SETTLE;
      ST_INIT_SETTLE: begin
        if (wait_q == SETTLE_LAST) begin
          inital_over_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_ad_cal_start && !cal_over_q) begin
          mode_d  = i_ad_mode;
          dly_d   = i_ad_dly;
          state_d = ST_M_LOAD;
        end
      end
      ST_M_LOAD: begin
        tx_data = mode_word(MODE_ADDR, mode_q);
        if (!tx_busy) begin
          tx_load = 1'b1;
          state_d = ST_M_FRAME;
        end
      end
      ST_M_FRAME: if (tx_done) state_d = ST_GAP;
      ST_GAP: begin
        if (wait_q == GAP_LAST) state_d = ST_D_LOAD;
        else                    wait_d  = wait_q + 1'b1;
      end
      ST_D_LOAD: begin
        tx_data = dly_word(DLY_ADDR, dly_q);
        if (!tx_busy) begin
          tx_load = 1'b1;
          state_d = ST_D_FRAME;
        end
      end
      ST_D_FRAME: if (tx_done) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (wait_q == SETTLE_LAST) begin
          cal_over_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DONE: begin
        // cal_over was set on entry, so it is high for at least one cycle.
        if (!i_ad_cal_start) begin
          cal_over_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PWRUP;
      wait_q        <= '0;
      mode_q        <= '0;
      dly_q         <= '0;
      cal_over_q    <= 1'b0;
      inital_over_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      mode_q        <= mode_d;
      dly_q         <= dly_d;
      cal_over_q    <= cal_over_d;
      inital_over_q <= inital_over_d;
    end
  end

  spi_word_tx #(
    .SCLK_DIV(SCLK_DIV)
  ) u_tx (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .i_load (tx_load),
    .i_data (tx_data),
    .o_busy (tx_busy),
    .o_done (tx_done),
    .o_sen  (o_spi_sen),
    .o_sclk (o_spi_sclk),
    .o_sdata(o_spi_sdata)
  );

  assign o_ad_cal_over    = cal_over_q;
  assign o_ad_inital_over = inital_over_q;

endmodule

// File: tb/tb_ads42_spi_cfg.sv
// Scoreboard bench for ads42_spi_cfg: stimulus queues expected SPI words,
// a bus monitor decodes frames and compares them as they complete.
module tb_ads42_spi_cfg;

  localparam int SCLK_DIV  = 2;
  localparam int PWRUP     = 16;
  localparam int GAP       = 4;
  localparam int SETTLE    = 8;
  localparam int FRAME_LOW = 33 * SCLK_DIV;                      // 66
  localparam int INIT_LAT  = PWRUP + 1 + FRAME_LOW + SETTLE;     // 91
  localparam int CAL_LAT   = 2 + 66 * SCLK_DIV + GAP + SETTLE;   // 146
  // SEN stays high through the GAP state plus the one-cycle load state.
  localparam int SEN_GAP   = GAP + 1;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_ad_mode;
  logic [2:0] i_ad_dly;
  logic       i_ad_cal_start;
  logic       o_ad_cal_over;
  logic       o_ad_inital_over;
  logic       o_spi_sen;
  logic       o_spi_sclk;
  logic       o_spi_sdata;

  always #5 sys_clk = ~sys_clk;

  ads42_spi_cfg #(
    .SCLK_DIV     (SCLK_DIV),
    .PWRUP_CYCLES (PWRUP),
    .GAP_CYCLES   (GAP),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .sys_clk         (sys_clk),
    .rst_n           (rst_n),
    .i_ad_mode       (i_ad_mode),
    .i_ad_dly        (i_ad_dly),
    .i_ad_cal_start  (i_ad_cal_start),
    .o_ad_cal_over   (o_ad_cal_over),
    .o_ad_inital_over(o_ad_inital_over),
    .o_spi_sen       (o_spi_sen),
    .o_spi_sclk      (o_spi_sclk),
    .o_spi_sdata     (o_spi_sdata)
  );

  typedef struct packed {
    logic        chk_gap;
    logic [15:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] word, input logic chk_gap);
    exp_t e;
    e.word    = word;
    e.chk_gap = chk_gap;
    exp_q.push_back(e);
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  bit          in_frame = 1'b0;
  int          sen_low, nbits, high_cnt;
  logic [15:0] word;
  logic        sclk_prev;

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      sen_low   = 0;
      nbits     = 0;
      high_cnt  = 0;
      sclk_prev = 1'b0;
    end else if (!o_spi_sen) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        sen_low  = 0;
        nbits    = 0;
        word     = '0;
        if (exp_q.size() > 0 && exp_q[0].chk_gap) check("sen_gap", high_cnt, SEN_GAP);
      end
      sen_low++;
      if (o_spi_sclk && !sclk_prev) begin
        word = {word[14:0], o_spi_sdata};
        nbits++;
      end
      sclk_prev = o_spi_sclk;
    end else begin
      if (in_frame) begin
        exp_t e;
        in_frame = 1'b0;
        high_cnt = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got 0x%04h, no frame expected at %0t", word, $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_word", word, e.word);
          check("sen_low_cycles", sen_low, FRAME_LOW);
          check("frame_bits", nbits, 16);
        end
      end else begin
        high_cnt++;
      end
      sclk_prev = o_spi_sclk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_init();
    int n = 0;
    int sen_fall = -1;
    while (!o_ad_inital_over && n < INIT_LAT + 100) begin
      @(posedge sys_clk); #1;
      n++;
      if (!o_spi_sen && sen_fall < 0) sen_fall = n;
    end
    check("init_sen_fall", sen_fall, PWRUP + 1);
    check("init_latency", n, INIT_LAT);
  endtask

  // Issue one request; early drops start mid-request, chg>0 alters the
  // inputs on that cycle to show the latched values are used.
  task automatic do_request(input logic [3:0] m, input logic [2:0] d,
                            input bit early, input int chg);
    int n = 0;
    i_ad_mode      = m;
    i_ad_dly       = d;
    i_ad_cal_start = 1'b1;
    while (!o_ad_cal_over && n < CAL_LAT + 100) begin
      @(posedge sys_clk); #1;
      n++;
      if (early && n == 3) i_ad_cal_start = 1'b0;
      if (chg > 0 && n == chg) begin
        i_ad_dly  = ~d;
        i_ad_mode = ~m;
      end
    end
    check("cal_latency", n, CAL_LAT + 1);
    if (early) begin
      @(posedge sys_clk); #1;
      check("cal_over_pulse", o_ad_cal_over, 1'b0);
    end else begin
      repeat (3) @(posedge sys_clk);
      #1;
      check("cal_over_hold", o_ad_cal_over, 1'b1);
      i_ad_cal_start = 1'b0;
      @(posedge sys_clk); #1;
      check("cal_over_fall", o_ad_cal_over, 1'b0);
    end
    check("frames_pending", exp_q.size(), 0);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    i_ad_mode      = '0;
    i_ad_dly       = '0;
    i_ad_cal_start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_sen", o_spi_sen, 1'b1);
    check("rst_sclk", o_spi_sclk, 1'b0);
    check("rst_sdata", o_spi_sdata, 1'b0);
    check("rst_cal_over", o_ad_cal_over, 1'b0);
    check("rst_inital_over", o_ad_inital_over, 1'b0);

    // Power-up soft reset frame
    push_exp(16'h0801, 1'b0);
    rst_n = 1'b1;
    wait_init();

    // Basic request: ramp mode, delay tap 3
    push_exp(16'h0F40, 1'b0);
    push_exp(16'h420B, 1'b1);
    do_request(4'b0100, 3'd3, 1'b0, 0);

    // Delay sweep, odd taps drop start mid-request
    for (int d = 0; d < 8; d++) begin
      push_exp(16'h0F40, 1'b0);
      push_exp({8'h42, 8'h08 | 8'(d)}, 1'b1);
      do_request(4'b0100, 3'(d), d[0], 0);
    end
    check("inital_over_sticky", o_ad_inital_over, 1'b1);

    // Inputs changed during the mode frame must not alter the words
    push_exp(16'h0F40, 1'b0);
    push_exp(16'h420B, 1'b1);
    do_request(4'b0100, 3'd3, 1'b0, 20);

    // Start raised during power-up is served right after init
    rst_n = 1'b0;
    exp_q.delete();
    i_ad_mode      = 4'b0100;
    i_ad_dly       = 3'd5;
    i_ad_cal_start = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    push_exp(16'h0801, 1'b0);
    push_exp(16'h0F40, 1'b0);
    push_exp(16'h420D, 1'b1);
    rst_n = 1'b1;
    wait_init();
    n = 0;
    while (!o_ad_cal_over && n < CAL_LAT + 100) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("early_start_latency", n, CAL_LAT + 1);
    i_ad_cal_start = 1'b0;
    @(posedge sys_clk); #1;
    check("early_start_fall", o_ad_cal_over, 1'b0);
    check("early_start_frames", exp_q.size(), 0);
    repeat (2) @(posedge sys_clk);
    #1;

    // Reset in the middle of the delay frame
    push_exp(16'h0F40, 1'b0);
    push_exp(16'h420A, 1'b1);
    i_ad_mode      = 4'b0100;
    i_ad_dly       = 3'd2;
    i_ad_cal_start = 1'b1;
    repeat (101) @(posedge sys_clk);
    #1;
    check("mid_frame_sen", o_spi_sen, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_sen", o_spi_sen, 1'b1);
    check("abort_sclk", o_spi_sclk, 1'b0);
    check("abort_cal_over", o_ad_cal_over, 1'b0);
    check("abort_inital_over", o_ad_inital_over, 1'b0);
    exp_q.delete();
    i_ad_cal_start = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    push_exp(16'h0801, 1'b0);
    rst_n = 1'b1;
    wait_init();
    repeat (5) @(posedge sys_clk);
    #1;
    check("final_frames", exp_q.size(), 0);
    check("final_cal_over", o_ad_cal_over, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
